// File: rtl/serial_parity_checker_pkg.sv
// Shared definitions for the serial parity receive path.
//   state_e    : receiver FSM states
//   START_BIT  : line level that opens a frame
//   STOP_BIT   : line level expected to close a frame
//   parity_of  : XOR reduction of a vector (even-parity bit of the vector)
package serial_parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic logic parity_of(input logic [31:0] vec);
    return ^vec;
  endfunction

endpackage

// File: rtl/serial_parity_checker_parity_accum.sv
// Registered XOR accumulator.
//   clk    : system clock
//   rst_n  : synchronous active-low reset, clears the accumulator
//   clr    : clear the accumulator on this edge (wins over en)
//   en     : fold bit_in into the accumulator on this edge
//   bit_in : bit to accumulate
//   acc    : running XOR of all bits accepted since the last clear
module parity_accum
  import serial_parity_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic acc
);

  logic acc_q;
  logic acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = 1'b0;
    end else if (en) begin
      acc_d = parity_of({30'd0, acc_q, bit_in});
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/serial_parity_checker.sv
// Serial parity checker: deserializes LSB-first frames of
// start bit, DATA_W data bits, parity bit, stop bit, and reports the word
// with parity and framing error flags.
//   clk        : system clock
//   rst_n      : synchronous active-low reset
//   bit_valid  : bit_in is sampled on this edge only when high
//   bit_in     : serial line bit
//   data_out   : last completed frame's data (LSB = first data bit)
//   data_valid : one-cycle pulse after the stop bit is sampled
//   parity_err : parity mismatch for the frame in data_out
//   frame_err  : stop bit was 0 for the frame in data_out
//   busy       : frame in progress (state != IDLE)
module serial_parity_checker
  import serial_parity_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter bit          ODD    = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                perr_q, perr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                dv_q, dv_d;
  logic                perr_out_q, perr_out_d;
  logic                ferr_q, ferr_d;
  logic                acc_clr;
  logic                acc_en;
  logic                acc;

  parity_accum u_parity_accum (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (acc_clr),
    .en     (acc_en),
    .bit_in (bit_in),
    .acc    (acc)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    perr_d     = perr_q;
    data_d     = data_q;
    dv_d       = 1'b0;
    perr_out_d = perr_out_q;
    ferr_d     = ferr_q;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bit_valid && (bit_in == START_BIT)) begin
          state_d = DATA;
          cnt_d   = '0;
          acc_clr = 1'b1;
        end
      end
      DATA: begin
        if (bit_valid) begin
          shreg_d[cnt_q] = bit_in;
          acc_en         = 1'b1;
          if (cnt_q == LAST_IDX) begin
            // Leave on the last index rather than on counter overflow.
            cnt_d   = '0;
            state_d = PARITY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_valid) begin
          perr_d  = acc ^ bit_in ^ ODD;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_valid) begin
          data_d     = shreg_q;
          perr_out_d = perr_q;
          ferr_d     = (bit_in != STOP_BIT);
          dv_d       = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      perr_q     <= 1'b0;
      data_q     <= '0;
      dv_q       <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      perr_q     <= perr_d;
      data_q     <= data_d;
      dv_q       <= dv_d;
      perr_out_q <= perr_out_d;
      ferr_q     <= ferr_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = dv_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_parity_checker.sv
module tb_serial_parity_checker;

  logic       clk;
  logic       rst_n;
  logic       bv0, bi0, bv1, bi1;
  logic [7:0] dout0, dout1;
  logic       dv0, perr0, ferr0, busy0;
  logic       dv1, perr1, ferr1, busy1;

  int n_checks;
  int n_errors;

  serial_parity_checker #(.DATA_W(8), .ODD(1'b0)) dut_even (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_valid  (bv0),
    .bit_in     (bi0),
    .data_out   (dout0),
    .data_valid (dv0),
    .parity_err (perr0),
    .frame_err  (ferr0),
    .busy       (busy0)
  );

  serial_parity_checker #(.DATA_W(8), .ODD(1'b1)) dut_odd (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_valid  (bv1),
    .bit_in     (bi1),
    .data_out   (dout1),
    .data_valid (dv1),
    .parity_err (perr1),
    .frame_err  (ferr1),
    .busy       (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called #1 after an active edge; leaves the bench #1 after the edge
  // that sampled the bit, with bit_valid already dropped.
  task automatic send_bit(input int sel, input logic b, input int gap);
    repeat (gap) @(posedge clk) #1;
    if (sel == 0) begin bv0 = 1'b1; bi0 = b; end
    else          begin bv1 = 1'b1; bi1 = b; end
    @(posedge clk) #1;
    if (sel == 0) begin bv0 = 1'b0; bi0 = 1'b1; end
    else          begin bv1 = 1'b0; bi1 = 1'b1; end
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input logic par,
                            input logic stp, input int maxgap);
    send_bit(sel, 1'b0, $urandom_range(maxgap, 0));
    for (int i = 0; i < 8; i++) send_bit(sel, d[i], $urandom_range(maxgap, 0));
    send_bit(sel, par, $urandom_range(maxgap, 0));
    send_bit(sel, stp, $urandom_range(maxgap, 0));
  endtask

  task automatic expect_even(input string tag, input logic [7:0] d,
                             input logic pe, input logic fe);
    check({tag, "_dv"},    32'(dv0),   32'd1);
    check({tag, "_data"},  32'(dout0), 32'(d));
    check({tag, "_perr"},  32'(perr0), 32'(pe));
    check({tag, "_ferr"},  32'(ferr0), 32'(fe));
    check({tag, "_busy"},  32'(busy0), 32'd0);
    @(posedge clk) #1;
    check({tag, "_dv_off"}, 32'(dv0),   32'd0);
    check({tag, "_hold"},   32'(dout0), 32'(d));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bv0 = 1'b0; bi0 = 1'b1;
    bv1 = 1'b0; bi1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data",  32'(dout0), 32'd0);
    check("rst_dv",    32'(dv0),   32'd0);
    check("rst_perr",  32'(perr0), 32'd0);
    check("rst_ferr",  32'(ferr0), 32'd0);
    check("rst_busy",  32'(busy0), 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);
    rst_n = 1'b1;
    @(posedge clk) #1;

    // 1: clean even-parity frame
    send_frame(0, 8'hA5, 1'b0, 1'b1, 0);
    expect_even("t1", 8'hA5, 1'b0, 1'b0);

    // 2: parity error
    send_frame(0, 8'h01, 1'b0, 1'b1, 0);
    expect_even("t2", 8'h01, 1'b1, 1'b0);

    // 3: framing error still produces data_valid
    send_frame(0, 8'h3C, 1'b0, 1'b0, 0);
    expect_even("t3", 8'h3C, 1'b0, 1'b1);

    // 4: idle ones ignored, then gapped frame
    for (int i = 0; i < 3; i++) send_bit(0, 1'b1, i);
    check("t4_idle_busy", 32'(busy0), 32'd0);
    check("t4_idle_dv",   32'(dv0),   32'd0);
    check("t4_idle_hold", 32'(dout0), 32'h3C);
    send_frame(0, 8'h5A, 1'b0, 1'b1, 3);
    expect_even("t4", 8'h5A, 1'b0, 1'b0);

    // 5: reset mid-frame
    send_bit(0, 1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(0, 1'b1, 0);
    check("t5_busy_mid", 32'(busy0), 32'd1);
    rst_n = 1'b0;
    @(posedge clk) #1;
    rst_n = 1'b1;
    check("t5_dv",   32'(dv0),   32'd0);
    check("t5_busy", 32'(busy0), 32'd0);
    check("t5_data", 32'(dout0), 32'd0);
    check("t5_perr", 32'(perr0), 32'd0);
    check("t5_ferr", 32'(ferr0), 32'd0);
    @(posedge clk) #1;
    check("t5_dv_after", 32'(dv0), 32'd0);
    send_frame(0, 8'h81, 1'b0, 1'b1, 0);
    expect_even("t5", 8'h81, 1'b0, 1'b0);

    // 6: odd parity, back-to-back frames
    send_frame(1, 8'h07, 1'b0, 1'b1, 0);
    check("t6a_dv",   32'(dv1),   32'd1);
    check("t6a_data", 32'(dout1), 32'h07);
    check("t6a_perr", 32'(perr1), 32'd0);
    check("t6a_ferr", 32'(ferr1), 32'd0);
    send_bit(1, 1'b0, 0);
    check("t6_start_accepted", 32'(busy1), 32'd1);
    check("t6_dv_off",         32'(dv1),   32'd0);
    for (int i = 0; i < 8; i++) send_bit(1, i < 2 ? 1'b1 : 1'b0, 0);
    send_bit(1, 1'b1, 0);
    send_bit(1, 1'b1, 0);
    check("t6b_dv",   32'(dv1),   32'd1);
    check("t6b_data", 32'(dout1), 32'h03);
    check("t6b_perr", 32'(perr1), 32'd0);
    check("t6b_ferr", 32'(ferr1), 32'd0);
    check("t6b_busy", 32'(busy1), 32'd0);
    @(posedge clk) #1;
    check("t6b_dv_off", 32'(dv1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
